// File: rtl/udp_img_pkt_parser.sv
// udp_img_pkt_parser: checks the header word of each UDP image packet,
// splits payload words into two RGB565 pixels and marks frame boundaries.
// Optional macro PKT_SEQ_CHECK_EN enables packet sequence-number checking.
module udp_img_pkt_parser #(
    parameter int          IMG_W = 640,
    parameter int          IMG_H = 480,
    parameter logic [15:0] MAGIC = 16'hA55A
) (
    input  logic        eth_rx_clk,
    input  logic        rst,
    input  logic        rec_en,
    input  logic [31:0] rec_data,
    input  logic        rec_pkt_done,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        wr_load,
    output logic        frame_done,
    output logic        sync_ok,
    output logic [15:0] pkt_err_cnt
);
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int PIX_W     = $clog2(FRAME_PIX + 1);

    typedef enum logic [1:0] {HDR, PAY, DROP} state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               pend_vld_q, pend_vld_d;
    logic [15:0]        pend_q, pend_d;
    logic               hold_vld_q, hold_vld_d;
    logic [31:0]        hold_q, hold_d;
    logic               wr_en_q, wr_en_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic               wr_load_q, wr_load_d;
    logic               frame_done_q, frame_done_d;
    logic               sync_ok_q, sync_ok_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
`ifdef PKT_SEQ_CHECK_EN
    logic [14:0]        exp_seq_q, exp_seq_d;
`else
    logic               unused_seq;
    assign unused_seq = ^rec_data[14:0];
`endif

    logic               busy;
    logic               emit;
    logic [15:0]        emit_px;

    assign busy = pend_vld_q | hold_vld_q;

    // Header decode, pixel emission with one word of holding storage, frame counting
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        pend_vld_d   = pend_vld_q;
        pend_d       = pend_q;
        hold_vld_d   = hold_vld_q;
        hold_d       = hold_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_load_d    = 1'b0;
        frame_done_d = 1'b0;
        sync_ok_d    = sync_ok_q;
        err_cnt_d    = err_cnt_q;
`ifdef PKT_SEQ_CHECK_EN
        exp_seq_d    = exp_seq_q;
`endif
        emit         = 1'b0;
        emit_px      = 16'h0000;

        // A header is only taken once earlier pixels have fully drained, so
        // wr_load can never collide with a pixel of the previous packet.
        if (state_q == HDR && rec_en && !busy) begin
            if (rec_data[31:16] != MAGIC) begin
                state_d = DROP;
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else if (rec_data[15]) begin
                wr_load_d = 1'b1;
                pix_cnt_d = '0;
                sync_ok_d = 1'b1;
                state_d   = PAY;
`ifdef PKT_SEQ_CHECK_EN
                exp_seq_d = 15'd1;
`endif
            end else if (!sync_ok_q) begin
                state_d = DROP;
`ifdef PKT_SEQ_CHECK_EN
            end else if (rec_data[14:0] == exp_seq_q) begin
                exp_seq_d = exp_seq_q + 15'd1;
                state_d   = PAY;
            end else begin
                state_d   = DROP;
                sync_ok_d = 1'b0;
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end
`else
            end else begin
                state_d = PAY;
            end
`endif
        end

        // Pending low half first, then the queued word, then the fresh word.
        if (pend_vld_q) begin
            emit       = 1'b1;
            emit_px    = pend_q;
            pend_vld_d = 1'b0;
        end else if (hold_vld_q) begin
            emit       = 1'b1;
            emit_px    = hold_q[31:16];
            pend_d     = hold_q[15:0];
            pend_vld_d = 1'b1;
            hold_vld_d = 1'b0;
        end else if (state_q == PAY && rec_en) begin
            emit       = 1'b1;
            emit_px    = rec_data[31:16];
            pend_d     = rec_data[15:0];
            pend_vld_d = 1'b1;
        end

        if (state_q == PAY && rec_en && busy) begin
            hold_d     = rec_data;
            hold_vld_d = 1'b1;
        end

        if (emit) begin
            wr_en_d   = 1'b1;
            wr_data_d = emit_px;
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (pix_cnt_q + 1'b1 == PIX_W'(FRAME_PIX)) begin
                // Last pixel of the frame: anything still queued is discarded.
                frame_done_d = 1'b1;
                sync_ok_d    = 1'b0;
                state_d      = DROP;
                pend_vld_d   = 1'b0;
                hold_vld_d   = 1'b0;
            end
        end

        // End of packet wins last; draining continues while in HDR.
        if (rec_pkt_done) state_d = HDR;
    end

    // Control state and registered outputs
    always_ff @(posedge eth_rx_clk) begin
        if (rst) begin
            state_q      <= HDR;
            pix_cnt_q    <= '0;
            pend_vld_q   <= 1'b0;
            hold_vld_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 16'h0000;
            wr_load_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sync_ok_q    <= 1'b0;
            err_cnt_q    <= 16'h0000;
`ifdef PKT_SEQ_CHECK_EN
            exp_seq_q    <= 15'd0;
`endif
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            pend_vld_q   <= pend_vld_d;
            hold_vld_q   <= hold_vld_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_load_q    <= wr_load_d;
            frame_done_q <= frame_done_d;
            sync_ok_q    <= sync_ok_d;
            err_cnt_q    <= err_cnt_d;
`ifdef PKT_SEQ_CHECK_EN
            exp_seq_q    <= exp_seq_d;
`endif
        end
    end

    // Pixel holding storage; qualified by the valid flags, so no reset needed
    always_ff @(posedge eth_rx_clk) begin
        pend_q <= pend_d;
        hold_q <= hold_d;
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign wr_load     = wr_load_q;
    assign frame_done  = frame_done_q;
    assign sync_ok     = sync_ok_q;
    assign pkt_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_udp_img_pkt_parser.sv
// Bench for udp_img_pkt_parser with a small 4x3 frame (12 pixels).
module tb_udp_img_pkt_parser;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec_en = 1'b0;
    logic [31:0] rec_data = 32'h0;
    logic        rec_pkt_done = 1'b0;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        wr_load;
    logic        frame_done;
    logic        sync_ok;
    logic [15:0] pkt_err_cnt;

    udp_img_pkt_parser #(.IMG_W(IMG_W), .IMG_H(IMG_H), .MAGIC(16'hA55A)) dut (
        .eth_rx_clk  (clk),
        .rst         (rst),
        .rec_en      (rec_en),
        .rec_data    (rec_data),
        .rec_pkt_done(rec_pkt_done),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_load     (wr_load),
        .frame_done  (frame_done),
        .sync_ok     (sync_ok),
        .pkt_err_cnt (pkt_err_cnt)
    );

    always #5 clk = ~clk;

    // Observed pixels, captured away from the rising edge
    logic [15:0] obs_d[$];
    logic        obs_f[$];
    int          load_cnt = 0;
    int          collide  = 0;
    int          stray_fd = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_d.push_back(wr_data);
            obs_f.push_back(frame_done);
        end else if (frame_done) begin
            stray_fd = stray_fd + 1;
        end
        if (wr_load) load_cnt = load_cnt + 1;
        if (wr_load && wr_en) collide = collide + 1;
    end

    // Expected pixels
    logic [15:0] exp_d[$];
    logic        exp_f[$];
    int          rd = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          l0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp = n_cmp + 1;
        assert (o === e) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(input logic [15:0] px, input logic last);
        exp_d.push_back(px);
        exp_f.push_back(last);
    endtask

    task automatic send_word(input logic [31:0] w);
        rec_en   = 1'b1;
        rec_data = w;
        step();
        rec_en   = 1'b0;
        step();
    endtask

    task automatic pkt_done();
        rec_pkt_done = 1'b1;
        step();
        rec_pkt_done = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".wr_en"},      {31'h0, wr_en},      32'h0);
        check({tag, ".wr_data"},    {16'h0, wr_data},    32'h0);
        check({tag, ".wr_load"},    {31'h0, wr_load},    32'h0);
        check({tag, ".frame_done"}, {31'h0, frame_done}, 32'h0);
        check({tag, ".sync_ok"},    {31'h0, sync_ok},    32'h0);
        check({tag, ".err_cnt"},    {16'h0, pkt_err_cnt}, 32'h0);
    endtask

    // Let the pipeline drain, then compare observed pixels against the scoreboard
    task automatic check_drain(input string tag);
        int n_obs;
        repeat (6) step();
        n_obs = obs_d.size() - rd;
        check({tag, ".count"}, n_obs, exp_d.size());
        for (int i = 0; i < exp_d.size() && i < n_obs; i++) begin
            check($sformatf("%s.px%0d", tag, i), {16'h0, obs_d[rd + i]}, {16'h0, exp_d[i]});
            check($sformatf("%s.fd%0d", tag, i), {31'h0, obs_f[rd + i]}, {31'h0, exp_f[i]});
        end
        rd = obs_d.size();
        exp_d.delete();
        exp_f.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        check_zero("reset");

        // 1: SOF packet with two payload words
        l0 = load_cnt;
        send_word(32'hA55A_8000);
        send_word(32'h1234_5678); push(16'h1234, 1'b0); push(16'h5678, 1'b0);
        send_word(32'h9ABC_DEF0); push(16'h9ABC, 1'b0); push(16'hDEF0, 1'b0);
        pkt_done();
        check_drain("t1");
        check("t1.load", load_cnt - l0, 1);
        check("t1.sync", {31'h0, sync_ok}, 32'h1);

        // 2: bad magic dropped with an error, next SOF accepted
        send_word(32'h1234_8000);
        for (int i = 0; i < 4; i++) send_word(32'hDEAD_0000 + i);
        pkt_done();
        check_drain("t2drop");
        check("t2.err", {16'h0, pkt_err_cnt}, 32'h1);
        l0 = load_cnt;
        send_word(32'hA55A_8000);
        send_word(32'h1111_2222); push(16'h1111, 1'b0); push(16'h2222, 1'b0);
        pkt_done();
        check_drain("t2ok");
        check("t2.load", load_cnt - l0, 1);
        check("t2.err2", {16'h0, pkt_err_cnt}, 32'h1);

        // 3: sequence 0 (SOF), 1, 3, 4
        do_reset();
        send_word(32'hA55A_8000);
        send_word(32'h0000_0001); push(16'h0000, 1'b0); push(16'h0001, 1'b0);
        pkt_done();
        send_word(32'hA55A_0001);
        send_word(32'h0101_0102); push(16'h0101, 1'b0); push(16'h0102, 1'b0);
        pkt_done();
        send_word(32'hA55A_0003);
        send_word(32'h0303_0304);
`ifndef PKT_SEQ_CHECK_EN
        push(16'h0303, 1'b0); push(16'h0304, 1'b0);
`endif
        pkt_done();
`ifdef PKT_SEQ_CHECK_EN
        check("t3.err", {16'h0, pkt_err_cnt}, 32'h1);
        check("t3.sync", {31'h0, sync_ok}, 32'h0);
`else
        check("t3.err", {16'h0, pkt_err_cnt}, 32'h0);
        check("t3.sync", {31'h0, sync_ok}, 32'h1);
`endif
        send_word(32'hA55A_0004);
        send_word(32'h0404_0405);
`ifndef PKT_SEQ_CHECK_EN
        push(16'h0404, 1'b0); push(16'h0405, 1'b0);
`endif
        pkt_done();
        check_drain("t3");
`ifdef PKT_SEQ_CHECK_EN
        check("t3.err4", {16'h0, pkt_err_cnt}, 32'h1);
`else
        check("t3.err4", {16'h0, pkt_err_cnt}, 32'h0);
`endif

        // 4: full frame, frame_done on the last pixel, extra word suppressed
        do_reset();
        send_word(32'hA55A_8000);
        for (int i = 0; i < (IMG_W * IMG_H) / 2; i++) begin
            send_word({16'hF000 + 16'(2 * i), 16'hF000 + 16'(2 * i + 1)});
            push(16'hF000 + 16'(2 * i), 1'b0);
            push(16'hF000 + 16'(2 * i + 1), (2 * i + 1) == (IMG_W * IMG_H - 1));
        end
        send_word(32'hEEEE_EEEE);
        pkt_done();
        check_drain("t4");
        check("t4.sync", {31'h0, sync_ok}, 32'h0);

        // 5: three back-to-back words
        do_reset();
        send_word(32'hA55A_8000);
        rec_en = 1'b1; rec_data = 32'hA0A1_A2A3; step();
        rec_data = 32'hB0B1_B2B3; step();
        rec_data = 32'hC0C1_C2C3; step();
        rec_en = 1'b0;
        push(16'hA0A1, 1'b0); push(16'hA2A3, 1'b0);
        push(16'hB0B1, 1'b0); push(16'hB2B3, 1'b0);
        push(16'hC0C1, 1'b0); push(16'hC2C3, 1'b0);
        check_drain("t5");
        pkt_done();

        // 6: reset between the high and low half
        do_reset();
        send_word(32'hA55A_8000);
        rec_en = 1'b1; rec_data = 32'h5555_6666; step();
        rec_en = 1'b0; rst = 1'b1; step();
        push(16'h5555, 1'b0);
        rst = 1'b0;
        check_zero("t6rst");
        check_drain("t6cut");
        l0 = load_cnt;
        send_word(32'hA55A_8000);
        send_word(32'h0BAD_F00D); push(16'h0BAD, 1'b0); push(16'hF00D, 1'b0);
        pkt_done();
        check_drain("t6");
        check("t6.load", load_cnt - l0, 1);

        // Global protocol checks
        check("collide", collide, 0);
        check("stray_fd", stray_fd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
